// File: rtl/hamming_uart_tx.sv
// hamming_uart_tx
//
// UART transmitter that Hamming-encodes a DATA_W-bit word when it is accepted
// and shifts the codeword out serially. Each frame is a start bit (0), the
// codeword from position CODE_W down to position 1, an optional overall parity
// bit, and STOP_BITS stop bits (1). A word offered in the last cycle of the
// last stop bit is accepted straight away, so back-to-back frames have no gap.
//
// Optional feature macro: HAMMING_TX_SECDED_EN
//   When defined, an even overall-parity bit (XOR of all codeword bits) is
//   sent in state PAR between codeword position 1 and the first stop bit.
//
// Parameters
//   DATA_W        payload width, 4..26
//   CLKS_PER_BIT  clk cycles per serial bit, >= 2
//   STOP_BITS     1 or 2
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   t_enable     in   source has a word to send
//   parallel_in  in   payload, sampled only in the accept cycle
//   ready        out  a word can be accepted this cycle
//   serial_out   out  registered UART line, idle high
//   busy         out  a frame is in progress
//   frame_done   out  one-cycle pulse in the last cycle of the last stop bit
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | line high, waiting for a word
// START | driving the start bit
// DATA  | driving codeword bits, position CODE_W down to 1
// PAR   | driving the overall parity bit (SECDED builds only)
// STOP  | driving stop bits; last cycle may accept the next word

module hamming_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_enable,
  input  logic [DATA_W-1:0] parallel_in,
  output logic              ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  function automatic int calc_par_w(input int dw);
    int p;
    p = 1;
    while ((1 << p) < (dw + p + 1)) p = p + 1;
    return p;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W;
  localparam int CYC_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(CODE_W + 4);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] CODE_LAST = BIT_W'(CODE_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Bit (pos-1) of the result holds codeword position pos. Data bits are
  // placed first; each parity bit is then the XOR of every position whose
  // index has the matching bit set. The parity position itself is still zero
  // at that point, so it does not disturb its own sum.
  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] cw;
    logic [DATA_W-1:0] rem;
    logic              acc;
    cw  = '0;
    rem = data;
    for (int pos = 1; pos <= CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (rem[0]) cw = cw | (CODE_W'(1) << (pos - 1));
        rem = rem >> 1;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      acc = 1'b0;
      for (int pos = 1; pos <= CODE_W; pos++) begin
        if (((pos >> k) & 1) == 1) acc = acc ^ (|(cw & (CODE_W'(1) << (pos - 1))));
      end
      if (acc) cw = cw | (CODE_W'(1) << ((1 << k) - 1));
    end
    return cw;
  endfunction

`ifdef HAMMING_TX_SECDED_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic              serial_q, serial_d;
`ifdef HAMMING_TX_SECDED_EN
  logic              par_q, par_d;
`endif

  logic [CODE_W-1:0] enc_code;
  logic              period_end;
  logic              stop_end;
  logic              accept;

  assign enc_code   = hamming_encode(parallel_in);
  assign period_end = (cyc_q == CYC_LAST);
  assign stop_end   = (state_q == STOP) && period_end && (bit_q == STOP_LAST);
  assign ready      = (state_q == IDLE) || stop_end;
  assign accept     = t_enable && ready;
  assign frame_done = stop_end;
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_q;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
`ifdef HAMMING_TX_SECDED_EN
    par_d    = par_q;
`endif

    if (state_q != IDLE) cyc_d = period_end ? '0 : cyc_q + CYC_W'(1);

    // The shift register MSB always holds the next codeword bit to send.
    case (state_q)
      IDLE: begin
      end
      START: begin
        if (period_end) begin
          state_d  = DATA;
          bit_d    = '0;
          serial_d = shift_q[CODE_W-1];
          shift_d  = shift_q << 1;
        end
      end
      DATA: begin
        if (period_end) begin
          if (bit_q == CODE_LAST) begin
            bit_d = '0;
`ifdef HAMMING_TX_SECDED_EN
            state_d  = PAR;
            serial_d = par_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_q + BIT_W'(1);
            serial_d = shift_q[CODE_W-1];
            shift_d  = shift_q << 1;
          end
        end
      end
`ifdef HAMMING_TX_SECDED_EN
      PAR: begin
        if (period_end) begin
          state_d  = STOP;
          bit_d    = '0;
          serial_d = 1'b1;
        end
      end
`endif
      STOP: begin
        if (period_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cyc_d    = '0;
        bit_d    = '0;
        serial_d = 1'b1;
      end
    endcase

    // Accept is only possible in IDLE or the final stop cycle; it overrides
    // the return to IDLE so the next start bit follows without a gap.
    if (accept) begin
      state_d  = START;
      cyc_d    = '0;
      bit_d    = '0;
      shift_d  = enc_code;
      serial_d = 1'b0;
`ifdef HAMMING_TX_SECDED_EN
      par_d    = ^enc_code;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
`ifdef HAMMING_TX_SECDED_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
`ifdef HAMMING_TX_SECDED_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Testbench for hamming_uart_tx: two instances (8-bit/1 stop and 16-bit/2 stop)
// driven with directed and random words; a monitor per instance decodes each
// frame against a queue of expected frames from a reference encoder.
module tb_hamming_uart_tx;

  localparam int CPB  = 4;
  localparam int DW_A = 8;
  localparam int CW_A = 12;
  localparam int SB_A = 1;
  localparam int DW_B = 16;
  localparam int CW_B = 21;
  localparam int SB_B = 2;
`ifdef HAMMING_TX_SECDED_EN
  localparam int SEC = 1;
`else
  localparam int SEC = 0;
`endif

  logic        clk;
  logic        rst_a, rst_b;
  logic        en_a, en_b;
  logic [7:0]  din_a;
  logic [15:0] din_b;
  logic        rdy_a, ser_a, busy_a, done_a;
  logic        rdy_b, ser_b, busy_b, done_b;

  hamming_uart_tx #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB), .STOP_BITS(SB_A)) dut_a (
    .clk(clk), .reset(rst_a), .t_enable(en_a), .parallel_in(din_a),
    .ready(rdy_a), .serial_out(ser_a), .busy(busy_a), .frame_done(done_a));

  hamming_uart_tx #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .reset(rst_b), .t_enable(en_b), .parallel_in(din_b),
    .ready(rdy_b), .serial_out(ser_b), .busy(busy_b), .frame_done(done_b));

  typedef struct {
    logic [31:0] code;
    logic        par;
    logic [31:0] known;
    bit          has_known;
    int          start;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   free_c[2];
  int   cyc;
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic get_ser(input int s);  return (s != 0) ? ser_b  : ser_a;  endfunction
  function automatic logic get_rdy(input int s);  return (s != 0) ? rdy_b  : rdy_a;  endfunction
  function automatic logic get_busy(input int s); return (s != 0) ? busy_b : busy_a; endfunction
  function automatic logic get_done(input int s); return (s != 0) ? done_b : done_a; endfunction
  function automatic logic get_rst(input int s);  return (s != 0) ? rst_b  : rst_a;  endfunction

  function automatic int nbits(input int s);
    return (s != 0) ? (1 + CW_B + SEC + SB_B) : (1 + CW_A + SEC + SB_A);
  endfunction

  // Reference encoder: data bits go to the non-power-of-two positions in
  // order; XOR of the indices of all set data positions gives the parity
  // vector, whose bit k is the parity bit at position 2^k.
  function automatic logic [31:0] ref_encode(input logic [31:0] data, input int dw);
    logic [31:0] cw;
    int          syn;
    int          pos;
    cw  = '0;
    syn = 0;
    pos = 0;
    for (int i = 0; i < dw; i++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      if (((data >> i) & 32'd1) != 0) begin
        cw  = cw | (32'd1 << (pos - 1));
        syn = syn ^ pos;
      end
    end
    for (int k = 0; (1 << k) <= pos; k++)
      if (((syn >> k) & 1) != 0) cw = cw | (32'd1 << ((1 << k) - 1));
    return cw;
  endfunction

  task automatic drive(input int s, input logic en, input logic [31:0] data);
    if (s != 0) begin
      en_b  = en;
      din_b = data[15:0];
    end else begin
      en_a  = en;
      din_a = data[7:0];
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    checks++;
    if (get_ser(s) !== 1'b1) begin errors++; $display("FAIL %s_serial dut%0d got %b required 1", tag, s, get_ser(s)); end
    checks++;
    if (get_busy(s) !== 1'b0) begin errors++; $display("FAIL %s_busy dut%0d got %b required 0", tag, s, get_busy(s)); end
    checks++;
    if (get_rdy(s) !== 1'b1) begin errors++; $display("FAIL %s_ready dut%0d got %b required 1", tag, s, get_rdy(s)); end
    checks++;
    if (get_done(s) !== 1'b0) begin errors++; $display("FAIL %s_frame_done dut%0d got %b required 0", tag, s, get_done(s)); end
  endtask

  // Called just after a rising edge. The accept cycle is predicted from the
  // model of when the block becomes free; returns just after the accept edge.
  task automatic send(input int s, input logic [31:0] data, input bit hold,
                      input logic [31:0] known, input bit has_known);
    exp_t e;
    int   acc;
    drive(s, 1'b1, data);
    acc         = (cyc > free_c[s]) ? cyc : free_c[s];
    e.code      = ref_encode(data, (s != 0) ? DW_B : DW_A);
    e.par       = ^e.code;
    e.known     = known;
    e.has_known = has_known;
    e.start     = acc + 1;
    @(negedge clk);
    while (cyc < acc) @(negedge clk);
    checks++;
    if (get_rdy(s) !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready dut%0d cycle %0d got %b required 1", s, cyc, get_rdy(s));
    end
    if (s != 0) q_b.push_back(e); else q_a.push_back(e);
    free_c[s] = acc + nbits(s) * CPB;
    @(posedge clk);
    #1;
    if (!hold) drive(s, 1'b0, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic wait_free(input int s);
    do begin
      @(posedge clk);
      #1;
    end while (cyc <= free_c[s] + 1);
  endtask

  task automatic monitor(input int s);
    exp_t        e;
    logic        ebits[64];
    int          cw, nb, start_cyc, bad_off;
    logic [31:0] got_code;
    bit          aborted, bit_ok, ctrl_ok, last;
    logic        got_v, bd, br, bb, bl;
    bad_off = 0; bd = 0; br = 0; bb = 0; bl = 0;
    cw = (s != 0) ? CW_B : CW_A;
    nb = nbits(s);
    forever begin
      @(negedge clk);
      if (get_rst(s) || get_ser(s) !== 1'b0) continue;
      start_cyc = cyc;
      if ((s != 0) ? (q_b.size() == 0) : (q_a.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame dut%0d cycle %0d got start bit required idle line", s, cyc);
        for (int i = 0; i < 400 && get_busy(s) === 1'b1; i++) @(negedge clk);
        continue;
      end
      e = (s != 0) ? q_b.pop_front() : q_a.pop_front();
      checks++;
      if (start_cyc != e.start) begin
        errors++;
        $display("FAIL start_cycle dut%0d got %0d required %0d", s, start_cyc, e.start);
      end
      ebits[0] = 1'b0;
      for (int i = 0; i < cw; i++) ebits[1 + i] = e.code[cw - 1 - i];
      if (SEC != 0) ebits[1 + cw] = e.par;
      for (int i = 1 + cw + SEC; i < nb; i++) ebits[i] = 1'b1;
      aborted  = 0;
      ctrl_ok  = 1;
      got_code = '0;
      for (int b = 0; b < nb && !aborted; b++) begin
        bit_ok = 1;
        got_v  = ebits[b];
        for (int c = 0; c < CPB && !aborted; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (get_rst(s)) begin
            aborted = 1;
          end else begin
            last = (b == nb - 1) && (c == CPB - 1);
            if (get_ser(s) !== ebits[b]) begin
              bit_ok = 0;
              got_v  = get_ser(s);
            end
            if (c == CPB / 2 && b >= 1 && b <= cw) got_code = (got_code << 1) | {31'd0, get_ser(s)};
            if (ctrl_ok && (get_done(s) !== last || get_rdy(s) !== last || get_busy(s) !== 1'b1)) begin
              ctrl_ok = 0;
              bad_off = cyc - start_cyc;
              bd = get_done(s); br = get_rdy(s); bb = get_busy(s); bl = last;
            end
          end
        end
        if (!aborted) begin
          checks++;
          if (!bit_ok) begin
            errors++;
            $display("FAIL frame_bit dut%0d bit %0d got %b required %b (held %0d cycles)", s, b, got_v, ebits[b], CPB);
          end
        end
      end
      if (aborted) continue;
      checks++;
      if (!ctrl_ok) begin
        errors++;
        $display("FAIL frame_ctrl dut%0d offset %0d got done=%b ready=%b busy=%b required done=%b ready=%b busy=1",
                 s, bad_off, bd, br, bb, bl, bl);
      end
      if (e.has_known) begin
        checks++;
        if (got_code !== e.known) begin
          errors++;
          $display("FAIL codeword dut%0d got %h required %h", s, got_code, e.known);
        end
      end
    end
  endtask

  task automatic mid_reset_a();
    @(negedge clk);
    #1 rst_a = 1'b1;
    #1 check_idle(0, "mid_reset");
    @(negedge clk);
    #1 rst_a = 1'b0;
    free_c[0] = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a();
    bit h;
    send(0, 32'hA5, 0, 32'hA27, 1);
    idle_cycles(3);
    send(0, 32'hFF, 0, 32'hF77, 1);
    idle_cycles(2);
    send(0, 32'h00, 0, 32'h000, 1);
    send(0, 32'h01, 0, 32'h007, 1);
    wait_free(0);
    send(0, 32'h3C, 1, 32'd0, 0);
    send(0, 32'hC3, 0, 32'd0, 0);
    wait_free(0);
    send(0, 32'h33, 0, 32'd0, 0);
    idle_cycles(CPB * 4);
    mid_reset_a();
    send(0, 32'h5A, 0, 32'h550, 1);
    wait_free(0);
    for (int i = 0; i < 20; i++) begin
      h = (i < 19) && ($urandom_range(0, 2) == 0);
      send(0, $urandom, h, 32'd0, 0);
      if (!h) idle_cycles($urandom_range(0, 30));
    end
  endtask

  task automatic run_b();
    bit h;
    for (int i = 0; i < 200; i++) begin
      h = (i < 199) && ($urandom_range(0, 2) == 0);
      send(1, $urandom, h, 32'd0, 0);
      if (!h) idle_cycles($urandom_range(0, 30));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    free_c[0] = 0;
    free_c[1] = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    din_a = '0;
    din_b = '0;
    #3;
    check_idle(0, "reset");
    check_idle(1, "reset");
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    check_idle(0, "after_reset");
    fork
      monitor(0);
      monitor(1);
    join_none
    fork
      run_a();
      run_b();
    join
    wait_free(0);
    wait_free(1);
    idle_cycles(4);
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL drain dut0 got %0d pending frames required 0", q_a.size()); end
    checks++;
    if (q_b.size() != 0) begin errors++; $display("FAIL drain dut1 got %0d pending frames required 0", q_b.size()); end
    check_idle(0, "end");
    check_idle(1, "end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
